// File: rtl/alu_result_stage.sv
// Result stage after the ALU: buffers results in a small FIFO and drains them as one
// or two 32-bit beats, updating architectural HI/LO and the zero/negative flags on retirement.
module alu_result_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 16,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEL_WIDTH-1:0]         alu_sel,
    input  logic [DATA_WIDTH-1:0]        z_high,
    input  logic [DATA_WIDTH-1:0]        z_low,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic                         out_is_high,
    output logic [DATA_WIDTH-1:0]        hi_reg,
    output logic [DATA_WIDTH-1:0]        lo_reg,
    output logic                         flag_zero,
    output logic                         flag_neg,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_MUL = SEL_WIDTH'(14);
    localparam logic [SEL_WIDTH-1:0] SEL_DIV = SEL_WIDTH'(15);

    logic [SEL_WIDTH-1:0]  r_memSel  [DEPTH];
    logic [DATA_WIDTH-1:0] r_memHigh [DEPTH];
    logic [DATA_WIDTH-1:0] r_memLow  [DEPTH];

    logic [PW-1:0]         r_wrPtr;
    logic [PW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_count;
    logic                  r_phase;
    logic [DATA_WIDTH-1:0] r_hiReg;
    logic [DATA_WIDTH-1:0] r_loReg;
    logic                  r_flagZero;
    logic                  r_flagNeg;

    logic [SEL_WIDTH-1:0]  w_headSel;
    logic [DATA_WIDTH-1:0] w_headHigh;
    logic [DATA_WIDTH-1:0] w_headLow;
    logic                  w_valid;
    logic                  w_headMulDiv;
    logic                  w_last;
    logic                  w_push;
    logic                  w_beat;
    logic                  w_pop;

    assign w_headSel    = r_memSel[r_rdPtr];
    assign w_headHigh   = r_memHigh[r_rdPtr];
    assign w_headLow    = r_memLow[r_rdPtr];
    assign w_valid      = (r_count != '0);
    assign w_headMulDiv = (w_headSel == SEL_MUL) || (w_headSel == SEL_DIV);
    assign w_last       = w_headMulDiv ? r_phase : 1'b1;

    // Outputs come only from registered state, so nothing from in_* reaches out_* combinationally.
    assign in_ready    = (r_count < FULL_COUNT);
    assign out_valid   = w_valid;
    assign out_last    = w_valid & w_last;
    assign out_is_high = w_valid & w_headMulDiv & r_phase;
    assign out_data    = !w_valid ? '0 : ((w_headMulDiv && r_phase) ? w_headHigh : w_headLow);

    assign w_push = in_valid & in_ready;
    assign w_beat = w_valid & out_ready;
    assign w_pop  = w_beat & w_last;

    assign hi_reg    = r_hiReg;
    assign lo_reg    = r_loReg;
    assign flag_zero = r_flagZero;
    assign flag_neg  = r_flagNeg;
    assign count     = r_count;

    // Entry storage needs no reset: only slots covered by count are ever read out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memSel[r_wrPtr]  <= alu_sel;
            r_memHigh[r_wrPtr] <= z_high;
            r_memLow[r_wrPtr]  <= z_low;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_phase <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PW'(1);
            end
            if (w_beat) begin
                r_phase <= ~w_last;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Architectural state changes on the same edge that pops the retiring entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hiReg    <= '0;
            r_loReg    <= '0;
            r_flagZero <= 1'b0;
            r_flagNeg  <= 1'b0;
        end else if (w_pop) begin
            if (w_headMulDiv) begin
                r_hiReg    <= w_headHigh;
                r_loReg    <= w_headLow;
                r_flagZero <= ({w_headHigh, w_headLow} == '0);
                r_flagNeg  <= w_headHigh[DATA_WIDTH-1];
            end else begin
                r_flagZero <= (w_headLow == '0);
                r_flagNeg  <= w_headLow[DATA_WIDTH-1];
            end
        end
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered result stage directly downstream of the ALU.
- Captures each ALU result (ZHigh/ZLow plus the ALU_Sel that produced it) into a small FIFO.
- Drains results to the bus/writeback side over a valid/ready handshake: mul/div (ALU_Sel 14/15) as two 32-bit beats, LO then HI; every other op as one beat.
- On retirement, maintains the architectural HI/LO registers and the zero/negative condition flags.

Parameters:
- DATA_WIDTH, 32, width of each result half and of out_data.
- SEL_WIDTH, 16, width of the captured ALU_Sel opcode.
- DEPTH, 2, number of FIFO entries; integer >= 2, not required to be a power of 2.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  stage can accept an entry
- alu_sel  input  SEL_WIDTH  opcode that produced the result
- z_high  input  DATA_WIDTH  ALU ZHigh
- z_low  input  DATA_WIDTH  ALU ZLow
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  consumer accepts the beat
- out_data  output  DATA_WIDTH  current beat data
- out_last  output  1  final beat of the current entry
- out_is_high  output  1  current beat is the HI half of a mul/div entry
- hi_reg  output  DATA_WIDTH  architectural HI
- lo_reg  output  DATA_WIDTH  architectural LO
- flag_zero  output  1  last retired result was zero
- flag_neg  output  1  last retired result was negative
- count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst_n low, asynchronous, any time, including mid two-beat drain):
  - count=0, read/write pointers=0, beat phase=0.
  - hi_reg=0, lo_reg=0, flag_zero=0, flag_neg=0.
  - out_valid=0, out_last=0, out_is_high=0, out_data=0.
  - In-flight entries are discarded. in_ready=1 in the first cycle after release.
- Push and pop:
  - in_ready = (count < DEPTH), derived from registered count only. No push-through when full, even if a pop occurs in the same cycle.
  - Push on in_valid && in_ready: store {alu_sel, z_high, z_low} at wr_ptr. wr_ptr wraps DEPTH-1 -> 0.
- Latency:
  - An entry pushed at edge N is visible with out_valid=1 in cycle N+1.
  - No combinational path from in_* to out_*.
- Beat sequencing (1-bit phase register):
  - Head sel in {14,15}:
    - phase 0: out_data=low, out_last=0, out_is_high=0.
    - phase 1: out_data=high, out_last=1, out_is_high=1.
  - Any other sel, including 0 and values >15: single beat, out_data=low, out_last=1, out_is_high=0.
  - A handshake (out_valid && out_ready) on a non-last beat sets phase=1.
  - A handshake on a last beat pops the entry (rd_ptr wraps), clears phase to 0, and performs retirement.
- Output stability: while out_valid && !out_ready, out_data, out_last and out_is_high hold constant.
- Count on simultaneous push and pop: count unchanged; both pointers advance.
- Retirement updates (same edge as the pop):
  - mul/div: hi_reg<=high, lo_reg<=low, flag_zero<=({high,low}==0), flag_neg<=high[DATA_WIDTH-1].
  - Other ops: hi_reg and lo_reg unchanged, flag_zero<=(low==0), flag_neg<=low[DATA_WIDTH-1].
- Empty: out_valid=0 and out_data=0. out_ready is ignored.

Test Plan:
- Reset, then push sel=12 with low=0x0000_0005, out_ready=1 -> out_valid rises the next cycle, one beat 0x5 with out_last=1. flag_zero=0, flag_neg=0, hi/lo unchanged at 0.
- Push sel=14 with high=0xFFFF_FFFF, low=0xFFFF_FFFA, out_ready=1 -> beat 0xFFFF_FFFA (last=0), then beat 0xFFFF_FFFF (last=1, is_high=1). After the second beat: hi_reg=0xFFFF_FFFF, lo_reg=0xFFFF_FFFA, flag_neg=1.
- out_ready=0, push 3 entries back-to-back with in_valid held high -> first two accepted, count=2, in_ready=0, third held. Raise out_ready -> entries drain in order, third accepted only after count drops to 1.
- Count=1 holding a single-beat entry, push and pop in the same cycle -> count stays 1, new entry appears next cycle, pointers wrap correctly across 10 consecutive entries.
- Push sel=15 with {high,low}=0, hold out_ready=0 for 3 cycles -> out_data stable at 0. Then drain -> flag_zero=1 after the HI beat.
- Assert rst_n low between the LO and HI beats of a sel=14 entry -> all outputs clear immediately, hi_reg/lo_reg stay 0, in_ready=1 after release, no stale beat appears.
